// File: rtl/ex_stage_md.sv
// Execute stage: two-level operand forwarding, single-cycle ALU/branch compare,
// iterative multiply/divide (built only when EX_MULDIV_EN is defined), EX/MEM register.
module ex_stage_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs,
  input  logic [4:0]      rt,
  input  logic [4:0]      wr_reg,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic [XLEN-1:0] imm,
  input  logic [SHW-1:0]  shamt,
  input  logic            src1_shamt,
  input  logic            src2_imm,
  input  logic [3:0]      alu_op,
  input  logic            sign,
  input  logic            branch,
  input  logic            reg_write,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            flush,
  input  logic            fwd1_we,
  input  logic            fwd2_we,
  input  logic [4:0]      fwd1_reg,
  input  logic [4:0]      fwd2_reg,
  input  logic [XLEN-1:0] fwd1_data,
  input  logic [XLEN-1:0] fwd2_data,
  output logic            pc_src_b,
  output logic            busy,
  output logic            out_valid,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_wr_reg
);

  logic [XLEN-1:0] rs_fwd, rt_fwd, op_a, op_b, alu_res, md_res;
  logic            is_md, in_ready_w, wb_en, accept;

  always_comb begin
    if (fwd1_we && (fwd1_reg == rs) && (fwd1_reg != 5'd0))      rs_fwd = fwd1_data;
    else if (fwd2_we && (fwd2_reg == rs) && (fwd2_reg != 5'd0)) rs_fwd = fwd2_data;
    else                                                        rs_fwd = rs_data;
    if (fwd1_we && (fwd1_reg == rt) && (fwd1_reg != 5'd0))      rt_fwd = fwd1_data;
    else if (fwd2_we && (fwd2_reg == rt) && (fwd2_reg != 5'd0)) rt_fwd = fwd2_data;
    else                                                        rt_fwd = rt_data;
  end

  assign op_a  = src1_shamt ? {{(XLEN-SHW){1'b0}}, shamt} : rs_fwd;
  assign op_b  = src2_imm ? imm : rt_fwd;
  assign is_md = (alu_op >= 4'd13);

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:  alu_res = op_a + op_b;
      4'd1:  alu_res = op_a - op_b;
      4'd2:  alu_res = op_a & op_b;
      4'd3:  alu_res = op_a | op_b;
      4'd4:  alu_res = op_a ^ op_b;
      4'd5:  alu_res = ~(op_a | op_b);
      4'd6:  alu_res = {{(XLEN-1){1'b0}},
                        (sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b))};
      4'd7:  alu_res = op_b << op_a[SHW-1:0];
      4'd8:  alu_res = op_b >> op_a[SHW-1:0];
      4'd9:  alu_res = $unsigned($signed(op_b) >>> op_a[SHW-1:0]);
      4'd10: alu_res = {{(XLEN-1){1'b0}}, (op_a == op_b)};
      4'd11: alu_res = {{(XLEN-1){1'b0}}, (op_a != op_b)};
      4'd12: alu_res = {{(XLEN-1){1'b0}}, op_a[XLEN-1]};
      default: alu_res = md_res;
    endcase
  end

`ifdef EX_MULDIV_EN
  // state  | meaning
  // IDLE   | no multiply/divide in flight
  // BUSY   | one shift-add or restoring step per cycle, XLEN steps
  // DONE   | sign-corrected result presented, EX/MEM captures it
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} md_state_t;

  localparam logic [1:0] K_MUL = 2'b01;
  localparam logic [1:0] K_DIV = 2'b10;
  localparam logic [1:0] K_REM = 2'b11;

  md_state_t       state_q, state_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d, opa_q, opa_d, opb_q, opb_d;
  logic [1:0]      kind_q, kind_d;
  logic            neg_q, neg_d, div0_q, div0_d;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] mag_a, mag_b, md_raw, md_val;
  logic [XLEN:0]   rem_sh, rem_diff;

  assign a_neg    = sign & op_a[XLEN-1];
  assign b_neg    = sign & op_b[XLEN-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;
  // Restoring divide: remainder in acc_q, dividend shifts out of opa_q as quotient shifts in.
  assign rem_sh   = {acc_q, opa_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, opb_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    kind_d  = kind_q;
    neg_d   = neg_q;
    div0_d  = div0_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && is_md && !flush) begin
          state_d = S_BUSY;
          cnt_d   = '0;
          acc_d   = '0;
          opa_d   = mag_a;
          opb_d   = mag_b;
          kind_d  = alu_op[1:0];
          neg_d   = (alu_op[1:0] == K_REM) ? a_neg : (a_neg ^ b_neg);
          div0_d  = (op_b == '0);
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          if (kind_q == K_MUL) begin
            acc_d = acc_q + (opb_q[0] ? opa_q : '0);
            opa_d = opa_q << 1;
            opb_d = opb_q >> 1;
          end else if (!rem_diff[XLEN]) begin
            acc_d = rem_diff[XLEN-1:0];
            opa_d = {opa_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = rem_sh[XLEN-1:0];
            opa_d = {opa_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + SHW'(1);
          if (cnt_q == SHW'(XLEN-1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      kind_q  <= '0;
      neg_q   <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      kind_q  <= kind_d;
      neg_q   <= neg_d;
      div0_q  <= div0_d;
    end
  end

  // Divide by zero bypasses sign correction so the quotient stays all ones.
  assign md_raw = (kind_q == K_DIV) ? opa_q : acc_q;
  assign md_val = ((kind_q == K_DIV) && div0_q) ? '1 : (neg_q ? -md_raw : md_raw);
  assign md_res = (state_q == S_DONE) ? md_val : '0;

  assign in_ready_w = ~(in_valid & is_md & (state_q != S_DONE));
  assign busy       = (state_q == S_BUSY) || (state_q == S_DONE);
  assign wb_en      = reg_write;
`else
  assign md_res     = '0;
  assign in_ready_w = 1'b1;
  assign busy       = 1'b0;
  assign wb_en      = reg_write & ~is_md;
`endif

  assign in_ready = in_ready_w;
  assign accept   = in_valid & in_ready_w & ~flush;
  assign pc_src_b = accept & branch & alu_res[0];

  logic            out_valid_q, out_valid_d, out_reg_write_q, out_reg_write_d;
  logic            out_mem_read_q, out_mem_read_d, out_mem_write_q, out_mem_write_d;
  logic [XLEN-1:0] out_result_q, out_result_d, out_store_data_q, out_store_data_d;
  logic [4:0]      out_wr_reg_q, out_wr_reg_d;

  // Bubbles clear the enables but hold the data fields.
  always_comb begin
    out_valid_d      = 1'b0;
    out_reg_write_d  = 1'b0;
    out_mem_read_d   = 1'b0;
    out_mem_write_d  = 1'b0;
    out_result_d     = out_result_q;
    out_store_data_d = out_store_data_q;
    out_wr_reg_d     = out_wr_reg_q;
    if (accept) begin
      out_valid_d      = 1'b1;
      out_reg_write_d  = wb_en;
      out_mem_read_d   = mem_read;
      out_mem_write_d  = mem_write;
      out_result_d     = alu_res;
      out_store_data_d = rt_fwd;
      out_wr_reg_d     = wr_reg;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_valid_q      <= 1'b0;
      out_reg_write_q  <= 1'b0;
      out_mem_read_q   <= 1'b0;
      out_mem_write_q  <= 1'b0;
      out_result_q     <= '0;
      out_store_data_q <= '0;
      out_wr_reg_q     <= '0;
    end else begin
      out_valid_q      <= out_valid_d;
      out_reg_write_q  <= out_reg_write_d;
      out_mem_read_q   <= out_mem_read_d;
      out_mem_write_q  <= out_mem_write_d;
      out_result_q     <= out_result_d;
      out_store_data_q <= out_store_data_d;
      out_wr_reg_q     <= out_wr_reg_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_reg_write  = out_reg_write_q;
  assign out_mem_read   = out_mem_read_q;
  assign out_mem_write  = out_mem_write_q;
  assign out_result     = out_result_q;
  assign out_store_data = out_store_data_q;
  assign out_wr_reg     = out_wr_reg_q;

endmodule

// File: doc/ex_stage_md.md
# ex_stage_md

Parametrised execute stage for the five-stage pipeline: resolves rs/rt operands through two-level forwarding, evaluates single-cycle ALU and branch-compare operations, and runs an iterative multi-cycle multiply/divide unit that stalls upstream through a ready handshake. It sits between the ID/EX and EX/MEM boundaries and owns the EX/MEM pipeline register. It also drives the branch-taken signal and supports squashing the instruction currently in EX.

## Interface
- XLEN, 32: datapath width; must be a power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount width.
- clk  in  1  clock, rising edge.
- reset_b  in  1  asynchronous, active-low reset.
- in_valid  in  1  ID/EX slot holds an instruction.
- in_ready  out  1  EX accepts the slot this cycle; upstream holds ID/EX while low.
- rs, rt, wr_reg  in  5 each  source registers and destination register.
- rs_data, rt_data  in  XLEN  register-file operands.
- imm  in  XLEN  extended immediate.
- shamt  in  SHW  shift amount.
- src1_shamt, src2_imm  in  1 each  select shamt for A and imm for B.
- alu_op  in  4  operation code.
- sign  in  1  signed compare and multiply/divide.
- branch, reg_write, mem_read, mem_write  in  1 each  control fields.
- flush  in  1  squash the EX instruction.
- fwd1_we, fwd2_we  in  1 each  EX/MEM and MEM/WB write enables.
- fwd1_reg, fwd2_reg  in  5 each  forwarding destination registers.
- fwd1_data, fwd2_data  in  XLEN  forwarding data.
- pc_src_b  out  1  branch taken (combinational).
- busy  out  1  multiply/divide in progress.
- out_valid, out_reg_write, out_mem_read, out_mem_write  out  1 each  registered EX/MEM control.
- out_result, out_store_data  out  XLEN  registered ALU result and forwarded rt.
- out_wr_reg  out  5  registered destination register.

## Operation
- Forwarding, evaluated independently per operand: fwd1 wins if we=1, reg matches, and reg≠0; otherwise fwd2 under the same rule; otherwise register-file data. rt uses its own match, never rs's.
- A = src1_shamt ? zero-extended shamt : rs_fwd. B = src2_imm ? imm : rt_fwd. out_store_data = rt_fwd.
- alu_op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT (signed if sign, else unsigned), 7 SLL B by A[SHW-1:0], 8 SRL, 9 SRA, 10 EQ, 11 NE, 12 LTZ (A signed <0), 13 MUL (low XLEN bits), 14 DIV (quotient), 15 REM.
- Compare ops produce 0 or 1 in bit 0. Add/sub wrap modulo 2^XLEN with no overflow trap.
- pc_src_b = in_valid & in_ready & branch & result[0] & ~flush.
- Multiply/divide FSM:
  - IDLE -> BUSY when in_valid & op∈{13,14,15} & ~flush. Magnitudes of A/B (sign-adjusted if sign) are latched and the counter cleared.
  - BUSY: one shift-add (MUL) or restoring step (DIV/REM) per cycle. Goes to DONE after XLEN iterations. Goes to IDLE on flush.
  - DONE: sign correction is applied; in_ready=1; the result is written to EX/MEM; goes to IDLE.
  - in_ready = ~(in_valid & muldiv op & state≠DONE). busy = state∈{BUSY,DONE}.
- Divide by zero: quotient all ones, remainder = dividend. Signed MIN/−1: quotient MIN, remainder 0.
- EX/MEM update each cycle:
  - flush, or in_valid=0, or in_ready=0: bubble, with out_valid and all out_* enables 0. Data fields are don't-care but deterministic (hold).
  - Otherwise the instruction is captured with out_valid=1.

## Timing
- Reset: all out_* = 0, busy = 0, FSM IDLE, counter 0. The reset is asynchronous and aborts any divide mid-run.
- Single-cycle ops: accepted at edge T, visible on out_* after T.
- MUL/DIV/REM: first presented at cycle T0. in_ready is low for XLEN+1 cycles (T0 through T0+XLEN). DONE occurs at cycle T0+XLEN+1, and the result edge ends that cycle. Total EX occupancy is XLEN+2 cycles.
- Operands are latched at T0. Forwarding changes during the stall do not affect the result.
- flush has priority over every other event, including DONE.

## Configuration
- EX_MULDIV_EN defined: FSM and iterative unit built as above.
- EX_MULDIV_EN undefined: ops 13–15 yield result 0 with out_reg_write forced to 0. in_ready is constant 1 and busy is constant 0. No FSM is built.

## Test plan
- rs=3, fwd1_we=1, fwd1_reg=3, fwd1_data=0x11, fwd2 also matching with 0x22, ADD with imm=1 (src2_imm) -> out_result=0x12. With fwd1_reg=0 -> 0x23.
- rt matches fwd2 only (0x5), rs unmatched, mem_write=1 -> out_store_data=0x5.
- EQ with rs_data=rt_data=7, branch=1 -> pc_src_b=1 same cycle. Same with flush=1 -> pc_src_b=0 and a bubble is written.
- DIV sign=1, A=−7, B=2, XLEN=32 -> in_ready low for 33 cycles, then out_result=0xFFFFFFFD. REM -> 0xFFFFFFFF.
- DIV by 0, A=9 -> 0xFFFFFFFF. REM -> 9. MUL 0xFFFF×0x10001 -> 0xFFFFFFFF.
- flush at iteration 10 of a MUL -> FSM IDLE next cycle, busy=0, no write. Deassert reset_b mid-divide -> all outputs 0 immediately.
